// File: rtl/llki_pkg.sv
// Shared LLKI definitions: key word width, key FSM state encoding and per-core mock TSS keys.
package llki_pkg;

  localparam int unsigned LLKI_KEY_WORD_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KEYED,
    ST_CLEAR
  } llki_state_e;

  // Word 0 is the rightmost element; each array converts directly to a flat MOCK_KEY value.
  localparam int unsigned MOCK_TSS_AES_NUM_KEY_WORDS = 2;
  localparam logic [MOCK_TSS_AES_NUM_KEY_WORDS-1:0][LLKI_KEY_WORD_WIDTH-1:0] MOCK_TSS_AES_KEY = {
    64'h0123_4567_89AB_CDEF,
    64'hFEDC_BA98_7654_3210
  };

  localparam int unsigned MOCK_TSS_SHA256_NUM_KEY_WORDS = 1;
  localparam logic [MOCK_TSS_SHA256_NUM_KEY_WORDS-1:0][LLKI_KEY_WORD_WIDTH-1:0] MOCK_TSS_SHA256_KEY = {
    64'hA5A5_5A5A_0F0F_F0F0
  };

  localparam int unsigned MOCK_TSS_DES3_NUM_KEY_WORDS = 3;
  localparam logic [MOCK_TSS_DES3_NUM_KEY_WORDS-1:0][LLKI_KEY_WORD_WIDTH-1:0] MOCK_TSS_DES3_KEY = {
    64'h1357_9BDF_2468_ACE0,
    64'hC001_D00D_BEEF_CAFE,
    64'h0F1E_2D3C_4B5A_6978
  };

endpackage

// File: rtl/mock_tss_key_fsm_p.sv
// LLKI discrete key loader: accepts KEY_WORDS words into the key register, and zeroizes
// it one word per cycle on a clear request.
module mock_tss_key_fsm_p
  import llki_pkg::*;
#(
  parameter int unsigned KEY_WORDS = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [LLKI_KEY_WORD_WIDTH-1:0]           i_key_data,
  input  logic                                     i_key_valid,
  output logic                                     o_key_ready,
  output logic                                     o_key_complete,
  input  logic                                     i_clear_key,
  output logic                                     o_clear_key_ack,
  output logic [$clog2(KEY_WORDS+1)-1:0]           o_word_cnt,
  output logic [KEY_WORDS*LLKI_KEY_WORD_WIDTH-1:0] o_key
);

  localparam int unsigned CW = $clog2(KEY_WORDS + 1);
  localparam logic [CW-1:0] LAST = CW'(KEY_WORDS - 1);

  llki_state_e r_state;
  llki_state_e w_next_state;
  logic [KEY_WORDS-1:0][LLKI_KEY_WORD_WIDTH-1:0] r_key;
  logic [CW-1:0] r_word_cnt;
  logic [CW-1:0] r_clr_idx;
  logic          r_ready;
  logic          r_complete;
  logic          r_ack;
  logic          w_clear_start;
  logic          w_accept;

  // Clear outranks a same-cycle word; r_ready already tracks IDLE/LOAD.
  always_comb begin
    w_next_state  = r_state;
    w_clear_start = i_clear_key && (r_state != ST_CLEAR);
    w_accept      = i_key_valid && r_ready && !w_clear_start;
    case (r_state)
      ST_IDLE, ST_LOAD: begin
        if (w_clear_start)  w_next_state = ST_CLEAR;
        else if (w_accept)  w_next_state = (r_word_cnt == LAST) ? ST_KEYED : ST_LOAD;
      end
      ST_KEYED: if (w_clear_start) w_next_state = ST_CLEAR;
      ST_CLEAR: if (r_clr_idx == LAST) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key      <= '0;
      r_word_cnt <= '0;
      r_clr_idx  <= '0;
      r_ready    <= 1'b0;
      r_complete <= 1'b0;
      r_ack      <= 1'b0;
    end else begin
      r_ready    <= (w_next_state == ST_IDLE) || (w_next_state == ST_LOAD);
      r_complete <= (w_next_state == ST_KEYED);
      r_ack      <= (r_state == ST_CLEAR) && (r_clr_idx == LAST);
      if (w_accept) begin
        for (int unsigned w = 0; w < KEY_WORDS; w++)
          if (CW'(w) == r_word_cnt) r_key[w] <= i_key_data;
        r_word_cnt <= r_word_cnt + CW'(1);
      end
      if (w_clear_start) begin
        r_clr_idx <= '0;
      end else if (r_state == ST_CLEAR) begin
        for (int unsigned w = 0; w < KEY_WORDS; w++)
          if (CW'(w) == r_clr_idx) r_key[w] <= '0;
        r_clr_idx <= r_clr_idx + CW'(1);
        if (r_clr_idx == LAST) r_word_cnt <= '0;
      end
    end
  end

  assign o_key_ready     = r_ready;
  assign o_key_complete  = r_complete;
  assign o_clear_key_ack = r_ack;
  assign o_word_cnt      = r_word_cnt;
  assign o_key           = r_key;

endmodule

// File: rtl/mock_tss_lanes.sv
// Mock TSS front-end: LLKI key loader plus a registered per-lane XOR mask on the core data path.
module mock_tss_lanes
  import llki_pkg::*;
#(
  parameter int unsigned KEY_WORDS  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_LANES  = 2,
  parameter logic [KEY_WORDS*LLKI_KEY_WORD_WIDTH-1:0] MOCK_KEY = '0,
  parameter logic KEY_GATE = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]   in_data,
  output logic                              out_valid,
  output logic [NUM_LANES*DATA_WIDTH-1:0]   out_data,
  input  logic [LLKI_KEY_WORD_WIDTH-1:0]    llkid_key_data,
  input  logic                              llkid_key_valid,
  output logic                              llkid_key_ready,
  output logic                              llkid_key_complete,
  input  logic                              llkid_clear_key,
  output logic                              llkid_clear_key_ack,
  output logic [$clog2(KEY_WORDS+1)-1:0]    key_word_cnt
);

  logic [KEY_WORDS*LLKI_KEY_WORD_WIDTH-1:0] w_key;
  logic [KEY_WORDS*LLKI_KEY_WORD_WIDTH-1:0] w_eff_key;
  logic [NUM_LANES*DATA_WIDTH-1:0]          w_mask;
  logic [NUM_LANES*DATA_WIDTH-1:0]          r_out_data;
  logic                                     r_out_valid;
  logic                                     w_unused_key_bits;

  mock_tss_key_fsm_p #(
    .KEY_WORDS(KEY_WORDS)
  ) u_key_fsm (
    .clk            (clk),
    .rst            (rst),
    .i_key_data     (llkid_key_data),
    .i_key_valid    (llkid_key_valid),
    .o_key_ready    (llkid_key_ready),
    .o_key_complete (llkid_key_complete),
    .i_clear_key    (llkid_clear_key),
    .o_clear_key_ack(llkid_clear_key_ack),
    .o_word_cnt     (key_word_cnt),
    .o_key          (w_key)
  );

  assign w_eff_key = MOCK_KEY ^ w_key;

  // Lanes reuse key words round-robin; only the low DATA_WIDTH bits of each word matter.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign w_mask[g*DATA_WIDTH +: DATA_WIDTH] =
      w_eff_key[(g % KEY_WORDS)*LLKI_KEY_WORD_WIDTH +: DATA_WIDTH];
  end

  assign w_unused_key_bits = ^w_eff_key;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid)
        r_out_data <= (KEY_GATE && !llkid_key_complete) ? '0 : (in_data ^ w_mask);
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_mock_tss_lanes.sv
// Directed self-checking bench: gated 4-word/2-lane instance plus an ungated 2-word/3-lane one.
`timescale 1ns/1ps
module tb_mock_tss_lanes;
  import llki_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        in_valid, out_valid;
  logic [63:0] in_data, out_data;
  logic [63:0] key_data;
  logic        key_valid, key_ready, key_complete, clear_key, clear_ack;
  logic [2:0]  word_cnt;

  logic        in2_valid, out2_valid;
  logic [47:0] in2_data, out2_data;
  logic [63:0] key2_data;
  logic        key2_valid, key2_ready, key2_complete, clear2, ack2;
  logic [1:0]  cnt2;

  mock_tss_lanes #(
    .KEY_WORDS(4), .DATA_WIDTH(32), .NUM_LANES(2), .MOCK_KEY('0), .KEY_GATE(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data),
    .llkid_key_data(key_data), .llkid_key_valid(key_valid), .llkid_key_ready(key_ready),
    .llkid_key_complete(key_complete), .llkid_clear_key(clear_key),
    .llkid_clear_key_ack(clear_ack), .key_word_cnt(word_cnt)
  );

  mock_tss_lanes #(
    .KEY_WORDS(2), .DATA_WIDTH(16), .NUM_LANES(3), .MOCK_KEY(MOCK_TSS_AES_KEY), .KEY_GATE(1'b0)
  ) dut2 (
    .clk(clk), .rst(rst), .in_valid(in2_valid), .in_data(in2_data),
    .out_valid(out2_valid), .out_data(out2_data),
    .llkid_key_data(key2_data), .llkid_key_valid(key2_valid), .llkid_key_ready(key2_ready),
    .llkid_key_complete(key2_complete), .llkid_clear_key(clear2),
    .llkid_clear_key_ack(ack2), .key_word_cnt(cnt2)
  );

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic        ev;
    logic [63:0] ed;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] kw [4];
    vec_t        tbl [6];
    logic [47:0] d;
    int          acks;
    int          first;
    logic [63:0] cnt_at_ack;

    kw[0] = 64'h1111_1111_1111_1111;
    kw[1] = 64'h2222_2222_2222_2222;
    kw[2] = 64'h3333_3333_3333_3333;
    kw[3] = 64'h4444_4444_4444_4444;
    tbl[0] = '{1'b1, 64'h0000_0000_0000_0000, 1'b1, 64'h2222_2222_1111_1111};
    tbl[1] = '{1'b1, 64'hFFFF_FFFF_0000_0000, 1'b1, 64'hDDDD_DDDD_1111_1111};
    tbl[2] = '{1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 64'hFC8F_9CCD_CFBC_AFFE};
    tbl[3] = '{1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'hFC8F_9CCD_CFBC_AFFE};
    tbl[4] = '{1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'h3016_745A_8BAD_CFE1};
    tbl[5] = '{1'b1, 64'hA5A5_A5A5_5A5A_5A5A, 1'b1, 64'h8787_8787_4B4B_4B4B};

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; key_data = '0; key_valid = 1'b0; clear_key = 1'b0;
    in2_valid = 1'b0; in2_data = '0; key2_data = '0; key2_valid = 1'b0; clear2 = 1'b0;
    #2;
    check("rst_ready",    64'(key_ready),    64'd0);
    check("rst_complete", 64'(key_complete), 64'd0);
    check("rst_ack",      64'(clear_ack),    64'd0);
    check("rst_cnt",      64'(word_cnt),     64'd0);
    check("rst_out_valid", 64'(out_valid),   64'd0);
    check("rst_out_data", out_data,          64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("ready_after_reset", 64'(key_ready), 64'd1);

    // Ungated instance: zero key register leaves only MOCK_KEY in the mask; lane 2 reuses word 0.
    in2_valid = 1'b1;
    in2_data  = {16'h0000, 16'hFFFF, 16'h1234};
    tick();
    check("u_valid", 64'(out2_valid), 64'd1);
    check("u_nokey", 64'(out2_data), 64'h3210_3210_2024);
    key2_valid = 1'b1;
    key2_data  = 64'hFEDC_BA98_7654_3210;
    tick();
    key2_data  = 64'h0123_4567_89AB_CDEF;
    tick();
    key2_valid = 1'b0;
    check("u_complete", 64'(key2_complete), 64'd1);
    check("u_ready",    64'(key2_ready),    64'd0);
    check("u_cnt",      64'(cnt2),          64'd2);
    for (int i = 0; i < 16; i++) begin
      d = 48'({$urandom(), $urandom()});
      in2_data = d;
      tick();
      check("u_match_passthru", 64'(out2_data), 64'(d));
    end
    clear2 = 1'b1;
    tick();
    clear2 = 1'b0;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (ack2) acks++;
    end
    check("u_clear_ack_count", 64'(acks), 64'd1);
    check("u_clear_cnt", 64'(cnt2), 64'd0);
    in2_data = {16'h0000, 16'hFFFF, 16'h1234};
    tick();
    check("u_key_zeroed", 64'(out2_data), 64'h3210_3210_2024);
    in2_valid = 1'b0;

    // Gated instance: partial key keeps data at zero.
    key_valid = 1'b1;
    key_data  = kw[0];
    tick();
    key_data  = kw[1];
    tick();
    key_valid = 1'b0;
    check("half_cnt",      64'(word_cnt),     64'd2);
    check("half_complete", 64'(key_complete), 64'd0);
    check("half_ready",    64'(key_ready),    64'd1);
    in_valid = 1'b1;
    in_data  = {32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tick();
    check("gate_valid", 64'(out_valid), 64'd1);
    check("gate_data",  out_data,       64'd0);
    key_valid = 1'b1;
    key_data  = kw[2];
    tick();
    key_data  = kw[3];
    tick();
    key_valid = 1'b0;
    check("full_complete", 64'(key_complete), 64'd1);
    check("full_ready",    64'(key_ready),    64'd0);
    check("full_cnt",      64'(word_cnt),     64'd4);
    tick();
    check("ungated_data", out_data, 64'hFC8F_9CCD_CFBC_AFFE);

    // Words offered while keyed must not disturb the key.
    key_valid = 1'b1;
    key_data  = '1;
    tick();
    tick();
    key_valid = 1'b0;
    check("keyed_cnt",   64'(word_cnt),  64'd4);
    check("keyed_ready", 64'(key_ready), 64'd0);

    for (int i = 0; i < 6; i++) begin
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      tick();
      check("vec_valid", 64'(out_valid), 64'(tbl[i].ev));
      check("vec_data",  out_data,       tbl[i].ed);
    end

    // Clear from KEYED: the data sampled on the clear edge still sees the old key.
    in_valid  = 1'b1;
    in_data   = '0;
    clear_key = 1'b1;
    tick();
    clear_key = 1'b0;
    check("clr_complete", 64'(key_complete), 64'd0);
    check("clr_ready",    64'(key_ready),    64'd0);
    check("clr_old_key",  out_data,          64'h2222_2222_1111_1111);
    acks = 0;
    first = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (clear_ack) begin
        acks++;
        if (first == 0) first = c;
      end
    end
    check("clr_ack_count", 64'(acks),      64'd1);
    check("clr_ack_cycle", 64'(first),     64'd4);
    check("clr_ready_back", 64'(key_ready), 64'd1);
    check("clr_cnt",       64'(word_cnt),  64'd0);

    // Clear together with a valid word: the word is dropped.
    key_valid = 1'b1;
    key_data  = 64'h5555_5555_5555_5555;
    tick();
    key_data  = 64'h6666_6666_6666_6666;
    clear_key = 1'b1;
    tick();
    clear_key = 1'b0;
    check("sim_cnt_discard", 64'(word_cnt), 64'd1);
    tick();
    key_valid = 1'b0;
    check("sim_cnt_hold", 64'(word_cnt), 64'd1);
    acks = 0;
    cnt_at_ack = '1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (clear_ack) begin
        acks++;
        cnt_at_ack = 64'(word_cnt);
      end
    end
    check("sim_ack_count", 64'(acks), 64'd1);
    check("sim_cnt_end",   cnt_at_ack, 64'd0);

    // Async reset in the middle of a clear.
    key_valid = 1'b1;
    for (int w = 0; w < 4; w++) begin
      key_data = kw[w];
      tick();
    end
    key_valid = 1'b0;
    in_valid  = 1'b1;
    in_data   = {32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tick();
    check("pre_rst_data", out_data, 64'hFC8F_9CCD_CFBC_AFFE);
    clear_key = 1'b1;
    tick();
    clear_key = 1'b0;
    tick();
    check("pre_rst_cnt", 64'(word_cnt), 64'd4);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid),    64'd0);
    check("arst_out_data",  out_data,          64'd0);
    check("arst_ready",     64'(key_ready),    64'd0);
    check("arst_complete",  64'(key_complete), 64'd0);
    check("arst_ack",       64'(clear_ack),    64'd0);
    check("arst_cnt",       64'(word_cnt),     64'd0);
    in_valid = 1'b0;
    acks = 0;
    tick();
    if (clear_ack) acks++;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (clear_ack) acks++;
    end
    check("arst_no_ack",  64'(acks),      64'd0);
    check("arst_ready_back", 64'(key_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
